// File: rtl/rr_arbiter3_pkg.sv
// Shared types and helpers for the three-requester arbiter.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package rr_arbiter3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN  = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_R0   = 2'b01;
  localparam logic [1:0] CODE_R1   = 2'b10;
  localparam logic [1:0] CODE_R2   = 2'b11;

  // Expand an owner code into the one-hot grant vector.
  function automatic logic [2:0] code_to_gnt(input logic [1:0] code);
    logic [2:0] g;
    case (code)
      CODE_R0: g = 3'b001;
      CODE_R1: g = 3'b010;
      CODE_R2: g = 3'b100;
      default: g = 3'b000;
    endcase
    return g;
  endfunction

  // Requester index (0..2) of an owner code; CODE_NONE maps to 0.
  function automatic logic [1:0] code_to_idx(input logic [1:0] code);
    logic [1:0] i;
    case (code)
      CODE_R1: i = 2'd1;
      CODE_R2: i = 2'd2;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/rr_arbiter3_prio_enc3.sv
// Fixed-priority encoder: bit 2 highest, returns owner code (11/10/01), 00 if idle.
// Latency: purely combinational.
// Backpressure: not applicable.
module prio_enc3
  import rr_arbiter3_pkg::*;
(
  input  logic [2:0] in,
  output logic [1:0] code
);

  // Highest set bit wins.
  always_comb begin
    if (in[2])      code = CODE_R2;
    else if (in[1]) code = CODE_R1;
    else if (in[0]) code = CODE_R0;
    else            code = CODE_NONE;
  end

endmodule

// File: rtl/rr_arbiter3.sv
// Three-requester arbiter, fixed or round-robin, with bounded hold and a dead GAP cycle.
// Latency: grant registered one cycle after req is sampled in IDLE; min 3 cycles between grants.
// Backpressure: requests are level-held and simply wait; nothing is dropped during OWN/GAP.
module rr_arbiter3
  import rr_arbiter3_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_rr,
  input  logic [2:0] req,
  input  logic       release_i,
  output logic [2:0] gnt,
  output logic [1:0] gnt_code,
  output logic       busy,
  output logic       timeout
);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_cnt_nxt;
  logic [1:0]    last_owner;
  logic [1:0]    last_owner_nxt;
  logic [1:0]    gnt_code_nxt;
  logic          timeout_nxt;

  logic [1:0]    shift;
  logic [2:0]    req_rot;
  logic [1:0]    rot_code;
  logic [1:0]    win_code;
  logic [2:0]    win_sum;

  logic          own_gone;
  logic          at_max;
  logic          exit_own;

  // Rotate requests so the requester just below last_owner lands on bit 2 in RR mode.
  always_comb begin
    shift = mode_rr ? last_owner : 2'd0;
    case (shift)
      2'd1:    req_rot = {req[0], req[2], req[1]};
      2'd2:    req_rot = {req[1], req[0], req[2]};
      default: req_rot = req;
    endcase
  end

  prio_enc3 u_enc (
    .in   (req_rot),
    .code (rot_code)
  );

  // Map the winning rotated position back to the real requester index.
  always_comb begin
    win_sum  = 3'd0;
    win_code = CODE_NONE;
    if (rot_code != CODE_NONE) begin
      win_sum = {1'b0, rot_code} - 3'd1 + {1'b0, shift};
      if (win_sum >= 3'd3) win_sum = win_sum - 3'd3;
      win_code = win_sum[1:0] + 2'd1;
    end
  end

  // OWN exit causes; timeout only reports the hold limit when it acted alone.
  always_comb begin
    own_gone = ~|(gnt & req);
    at_max   = (hold_cnt == CW'(MAX_HOLD - 1));
    exit_own = release_i | own_gone | at_max;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|req)    state_nxt = ST_OWN;
      ST_OWN:  if (exit_own) state_nxt = ST_GAP;
      ST_GAP:               state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the grant, hold counter, rotation pointer and timeout pulse.
  always_comb begin
    gnt_code_nxt   = gnt_code;
    hold_cnt_nxt   = hold_cnt;
    last_owner_nxt = last_owner;
    timeout_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        gnt_code_nxt = (|req) ? win_code : CODE_NONE;
        hold_cnt_nxt = '0;
      end
      ST_OWN: begin
        if (exit_own) begin
          gnt_code_nxt   = CODE_NONE;
          last_owner_nxt = code_to_idx(gnt_code);
          timeout_nxt    = at_max & ~release_i & ~own_gone;
        end else begin
          hold_cnt_nxt = hold_cnt + CW'(1);
        end
      end
      default: gnt_code_nxt = CODE_NONE;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= 3'b000;
      gnt_code   <= CODE_NONE;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= 2'd0;
    end else begin
      gnt        <= code_to_gnt(gnt_code_nxt);
      gnt_code   <= gnt_code_nxt;
      busy       <= (state_nxt != ST_IDLE);
      timeout    <= timeout_nxt;
      hold_cnt   <= hold_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter3.sv
// Directed self-checking bench for rr_arbiter3 (MAX_HOLD=4 main instance, MAX_HOLD=1 side instance).
// Latency: inputs driven 1 ns after posedge, outputs sampled at the same point.
// Backpressure: not applicable.
module tb_rr_arbiter3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode_rr;
  logic [2:0] req;
  logic       release_i;

  logic [2:0] gnt,  gnt1;
  logic [1:0] gnt_code, gnt_code1;
  logic       busy, busy1;
  logic       timeout, timeout1;

  int n_cmp = 0;
  int n_err = 0;

  rr_arbiter3 #(.MAX_HOLD(4), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_rr   (mode_rr),
    .req       (req),
    .release_i (release_i),
    .gnt       (gnt),
    .gnt_code  (gnt_code),
    .busy      (busy),
    .timeout   (timeout)
  );

  rr_arbiter3 #(.MAX_HOLD(1), .CW(4)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_rr   (mode_rr),
    .req       (req),
    .release_i (release_i),
    .gnt       (gnt1),
    .gnt_code  (gnt_code1),
    .busy      (busy1),
    .timeout   (timeout1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int g, input int c, input int b, input int t);
    chk({tag, ".gnt"},      32'(gnt),      32'(g));
    chk({tag, ".gnt_code"}, 32'(gnt_code), 32'(c));
    chk({tag, ".busy"},     32'(busy),     32'(b));
    chk({tag, ".timeout"},  32'(timeout),  32'(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int exp_g [4] = '{4, 2, 1, 4};
  int exp_c [4] = '{3, 2, 1, 3};

  initial begin
    rst_n     = 1'b0;
    mode_rr   = 1'b0;
    req       = 3'b000;
    release_i = 1'b0;
    step();
    step();
    chk_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Fixed priority, everyone requesting: req2 always wins.
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();          chk_all("fix.own0", 4, 3, 1, 0);
      step();          chk_all("fix.own1", 4, 3, 1, 0);
      release_i = 1'b1;
      step();
      release_i = 1'b0;
      chk_all("fix.gap", 0, 0, 1, 0);
      step();          chk_all("fix.idle", 0, 0, 0, 0);
    end

    // Round-robin from reset: 2, 1, 0, 2.
    rst_pulse();
    mode_rr = 1'b1;
    req     = 3'b111;
    for (int i = 0; i < 4; i++) begin
      release_i = 1'b1;
      step();          chk_all("rr.own", exp_g[i], exp_c[i], 1, 0);
      step();
      release_i = 1'b0;
      chk_all("rr.gap", 0, 0, 1, 0);
      step();          chk_all("rr.idle", 0, 0, 0, 0);
    end

    // Hold limit: MAX_HOLD=4 on dut, MAX_HOLD=1 on dut1.
    rst_pulse();
    mode_rr   = 1'b0;
    req       = 3'b010;
    release_i = 1'b0;
    step();  chk_all("to.c0", 2, 2, 1, 0);
             chk("mh1.own", 32'(gnt1), 32'd2);
             chk("mh1.own_to", 32'(timeout1), 32'd0);
    step();  chk_all("to.c1", 2, 2, 1, 0);
             chk("mh1.gap_gnt", 32'(gnt1), 32'd0);
             chk("mh1.gap_to", 32'(timeout1), 32'd1);
             chk("mh1.gap_busy", 32'(busy1), 32'd1);
    step();  chk_all("to.c2", 2, 2, 1, 0);
             chk("mh1.idle_busy", 32'(busy1), 32'd0);
             chk("mh1.idle_to", 32'(timeout1), 32'd0);
    step();  chk_all("to.c3", 2, 2, 1, 0);
             chk("mh1.regrant", 32'(gnt1), 32'd2);
    step();  chk_all("to.gap", 0, 0, 1, 1);
    step();  chk_all("to.idle", 0, 0, 0, 0);
    step();  chk_all("to.regrant", 2, 2, 1, 0);

    // Release coinciding with the hold limit: no timeout.
    step();
    step();
    step();  chk_all("rel_max.c3", 2, 2, 1, 0);
    release_i = 1'b1;
    step();
    release_i = 1'b0;
    chk_all("rel_max.gap", 0, 0, 1, 0);
    step();  chk_all("rel_max.idle", 0, 0, 0, 0);

    // Owner withdraws mid-grant, lower requester served after IDLE.
    req = 3'b011;
    step();  chk_all("wd.own0", 2, 2, 1, 0);
    step();  chk_all("wd.own1", 2, 2, 1, 0);
    req = 3'b001;
    step();  chk_all("wd.gap", 0, 0, 1, 0);
    step();  chk_all("wd.idle", 0, 0, 0, 0);
    step();  chk_all("wd.req0", 1, 1, 1, 0);
    release_i = 1'b1;
    step();
    release_i = 1'b0;
    step();

    // Asynchronous reset mid-OWN clears the rotation pointer.
    mode_rr = 1'b1;
    req     = 3'b111;
    step();  chk_all("ar.first", 4, 3, 1, 0);
    release_i = 1'b1;
    step();
    release_i = 1'b0;
    step();
    step();  chk_all("ar.second", 2, 2, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("ar.async", 0, 0, 0, 0);
    step();  chk_all("ar.held", 0, 0, 0, 0);
    rst_n = 1'b1;
    step();  chk_all("ar.after", 4, 3, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter3.md
Name: rr_arbiter3

Overview:
- Sequential arbiter that shares one downstream resource between three requesters (req[2..0]).
- Arbitration uses the team's 3-input priority encoding: req2 -> code 11, req1 -> 10, req0 -> 01, none -> 00.
- Two modes, selectable at run time:
  - fixed priority (2 > 1 > 0);
  - round-robin, which rotates priority past the last owner.
- Enforces a bounded hold time per grant; sits between the requesting units and the shared datapath.

Parameters:
- MAX_HOLD, 15, maximum consecutive cycles one owner may hold the grant (legal range 1..2^CW-1).
- CW, 4, width of the hold counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- mode_rr  input  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
- req  input  3  request lines, bit i = requester i; level-held until served.
- release_i  input  1  current owner is finished; meaningful only in OWN.
- gnt  output  3  one-hot grant, registered.
- gnt_code  output  2  encoded owner (11/10/01), 00 when no grant; registered.
- busy  output  1  high in OWN and GAP.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE, gnt = 000, gnt_code = 00, busy = 0, timeout = 0;
  - hold_cnt = 0, last_owner = 0.
- States: IDLE, OWN, GAP; 2-bit encoding.
- IDLE:
  - If req != 000 at a rising edge: load gnt/gnt_code for the winner, clear hold_cnt, go to OWN. The grant is visible in the cycle after req is sampled (1-cycle latency).
  - If req == 000: stay in IDLE, all outputs 0.
- Winner selection (combinational, evaluated in IDLE):
  - Fixed mode: search order 2, 1, 0.
  - Round-robin mode: search starts just below last_owner, descending with wrap.
    - last_owner = 2 -> order 1, 0, 2.
    - last_owner = 1 -> order 0, 2, 1.
    - last_owner = 0 -> order 2, 1, 0.
  - Reset value last_owner = 0, so the first RR decision after reset equals fixed priority.
- OWN:
  - gnt, gnt_code and busy held stable; hold_cnt increments each cycle.
  - Exit to GAP at the edge where any of these holds:
    - (a) release_i = 1;
    - (b) req[owner] = 0 (requester withdrew);
    - (c) hold_cnt == MAX_HOLD-1 (owner has held MAX_HOLD cycles).
  - On exit: gnt -> 000, gnt_code -> 00, last_owner <= owner.
  - timeout = 1 for exactly the GAP cycle, and only when (c) is the sole cause.
  - If (a) or (b) coincides with (c), timeout stays 0.
  - With MAX_HOLD = 1, every grant lasts exactly 1 cycle.
- GAP:
  - One dead cycle with gnt = 000 and busy = 1; always returns to IDLE.
  - No back-to-back grants; the minimum period between grants is 3 cycles.
- Requests arriving during OWN or GAP are not lost; they are arbitrated in the next IDLE.
- A change of mode_rr during OWN or GAP takes effect only at the next IDLE decision.
- last_owner is updated in both modes, so switching to RR rotates correctly.
- gnt is always one-hot or zero, and gnt_code always matches gnt.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE/ST_OWN/ST_GAP;
  - code constants CODE_NONE = 00, CODE_R0 = 01, CODE_R1 = 10, CODE_R2 = 11;
  - a function mapping code to one-hot grant.
- Sub-module prio_enc3: purely combinational 3-in / 2-bit-code fixed-priority encoder.
  - rr_arbiter3 rotates req according to mode and last_owner, feeds it to prio_enc3, and un-rotates the result.
- FSM, hold counter and output registers live in rr_arbiter3.

Test Plan:
- Reset then req = 111, mode_rr = 0, release_i pulsed 2 cycles after each grant -> grants 100, 100, 100… (gnt_code 11) while req2 stays high; busy pattern OWN, GAP, IDLE repeats.
- mode_rr = 1, req = 111 held, release_i after 1 OWN cycle -> grant sequence req2, req1, req0, req2 (codes 11, 10, 01, 11); timeout never asserts.
- MAX_HOLD = 4, req = 010 held, release_i = 0 -> gnt = 010 for exactly 4 cycles; timeout = 1 in the GAP cycle; regrant follows after IDLE.
- release_i = 1 in the same cycle hold_cnt reaches MAX_HOLD-1 -> exit to GAP with timeout = 0.
- Owner req1 withdraws (req 011 -> 001) mid-OWN -> GAP next edge; req0 granted (gnt 001, code 01) two edges later.
- rst_n driven low asynchronously mid-OWN (between clock edges) -> gnt, gnt_code, busy and timeout go to 0 immediately; after release, the first RR grant for req = 111 goes to req2.
